// File: rtl/ase_hssi_arb_pkg.sv
// Shared types and helpers for the HSSI TX packet arbiter.
package ase_hssi_arb_pkg;

  localparam int MAX_NUM_SRC = 16;
  localparam int SRC_IDX_W   = $clog2(MAX_NUM_SRC);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  // Round-robin pick: first set bit of req in circular order starting at last+1.
  // The request vector is zero-extended to MAX_NUM_SRC, so wrapping mod 16 over
  // the empty upper bits lands on index 0 exactly as a mod-NUM_SRC wrap would.
  function automatic logic [MAX_NUM_SRC-1:0] rr_pick(
    input logic [MAX_NUM_SRC-1:0] req,
    input logic [SRC_IDX_W-1:0]   last
  );
    logic [MAX_NUM_SRC-1:0] sel;
    logic [SRC_IDX_W-1:0]   idx;
    logic                   found;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_NUM_SRC; k++) begin
      idx = last + SRC_IDX_W'(k);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ase_hssi_axis_skid.sv
// Two-entry AXI-Stream register slice: an output register plus one skid register.
// in_ready depends only on registered state, so it never combinationally follows out_ready.
module ase_hssi_axis_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             push;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;

  // Advance the output register when it is free or draining; park the input in the skid otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_ready || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/ase_hssi_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one HSSI TX AXI-Stream channel.
// A source owns the channel from grant until its tlast beat is accepted; tx_pause
// only blocks new grants.
module ase_hssi_tx_pkt_arbiter
  import ase_hssi_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 1,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC-1:0]             src_tvalid,
  output logic [NUM_SRC-1:0]             src_tready,
  input  logic [NUM_SRC-1:0]             src_tlast,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0] src_tdata,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0] src_tuser,
  input  logic [NUM_SRC*TKEEP_WIDTH-1:0] src_tkeep,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic                           out_tlast,
  output logic [TDATA_WIDTH-1:0]         out_tdata,
  output logic [TUSER_WIDTH-1:0]         out_tuser,
  output logic [TKEEP_WIDTH-1:0]         out_tkeep,
  input  logic                           tx_pause,
  output logic [NUM_SRC-1:0]             grant,
  output logic                           pkt_active
);

  localparam int BEAT_W = 1 + TUSER_WIDTH + TKEEP_WIDTH + TDATA_WIDTH;

  t_arb_state             state, state_nxt;
  logic [NUM_SRC-1:0]     grant_nxt, grant_pick;
  logic [SRC_IDX_W-1:0]   last_grant, last_grant_nxt, grant_idx;
  logic                   skid_in_ready, xfer, sel_last;
  logic [TDATA_WIDTH-1:0] sel_tdata;
  logic [TUSER_WIDTH-1:0] sel_tuser;
  logic [TKEEP_WIDTH-1:0] sel_tkeep;

  assign grant_pick = NUM_SRC'(rr_pick(MAX_NUM_SRC'(src_tvalid), last_grant));
  assign src_tready = (state == ARB_LOCKED) ? (grant & {NUM_SRC{skid_in_ready}}) : '0;
  assign xfer       = |(src_tvalid & src_tready);
  assign pkt_active = (state == ARB_LOCKED);

  // Select the granted source's beat and index; grant is one-hot or zero.
  always_comb begin
    sel_tdata = '0;
    sel_tuser = '0;
    sel_tkeep = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_tdata = src_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_tuser = src_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        sel_tkeep = src_tkeep[i*TKEEP_WIDTH +: TKEEP_WIDTH];
        sel_last  = src_tlast[i];
        grant_idx = SRC_IDX_W'(i);
      end
    end
  end

  // Arbitration FSM next-state: grant in IDLE unless paused, release on accepted tlast.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      ARB_IDLE: begin
        grant_nxt = '0;
        if (!tx_pause && |src_tvalid) begin
          grant_nxt = grant_pick;
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (xfer && sel_last) begin
          last_grant_nxt = grant_idx;
          grant_nxt      = '0;
          state_nxt      = ARB_IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // Arbitration state registers; source 0 has first priority out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= SRC_IDX_W'(NUM_SRC-1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  ase_hssi_axis_skid #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer),
    .in_ready  (skid_in_ready),
    .in_data   ({sel_last, sel_tuser, sel_tkeep, sel_tdata}),
    .out_valid (out_tvalid),
    .out_ready (out_tready),
    .out_data  ({out_tlast, out_tuser, out_tkeep, out_tdata})
  );

endmodule
